rca64_seq_wrapper: RTL and testbench



---
 rtl/rca64_pkg.sv | 6 +
 rtl/Ripple_Carry_Addr_64bit.sv | 16 +
 rtl/rca64_seq_wrapper.sv | 70 +++++++
 tb/tb_rca64_seq_wrapper.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rca64_pkg.sv
// rca64_pkg: shared width, settle-counter width and FSM encoding for the rca64 wrapper
package rca64_pkg;
  localparam int RCA64_W = 64;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2} rca64_state_t;
endpackage

// File: rtl/Ripple_Carry_Addr_64bit.sv
// Ripple_Carry_Addr_64bit: combinational 64-bit ripple-carry adder, one full adder per bit
module Ripple_Carry_Addr_64bit (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        cin,
  output logic [63:0] S,
  output logic        cout
);
  logic [64:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 64; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign cout = c[64];
endmodule

// File: rtl/rca64_seq_wrapper.sv
// rca64_seq_wrapper: handshaked, registered add/subtract around Ripple_Carry_Addr_64bit
// Optional signed-overflow output out_ovf enabled by RCA64_OVF_EN.
module rca64_seq_wrapper
  import rca64_pkg::*;
#(
  parameter int WIDTH = RCA64_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef RCA64_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);
  rca64_state_t state, state_n;
  logic [WIDTH-1:0] a_q, b_q, add_b, s;
  logic cin_q, sub_q, add_cin, cout;
  logic [CNT_W-1:0] cnt;
  // subtract is A + ~B + 1, so the latched carry-in is overridden
  assign add_b = sub_q ? ~b_q : b_q;
  assign add_cin = sub_q | cin_q;
  Ripple_Carry_Addr_64bit u_add (.A(a_q), .B(add_b), .cin(add_cin), .S(s), .cout(cout));
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_n = state == IDLE   ? (in_valid ? SETTLE : IDLE) :
              state == SETTLE ? (cnt == '0 ? DONE : SETTLE) :
              state == DONE   ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      sub_q <= 1'b0;
      cnt <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
`ifdef RCA64_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_q <= in_a;
      b_q <= in_b;
      cin_q <= in_cin;
      sub_q <= in_sub;
      cnt <= CNT_W'(SETTLE_CYCLES - 1);
    end else if (state == SETTLE) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      else begin
        out_sum <= s;
        out_cout <= cout;
`ifdef RCA64_OVF_EN
        out_ovf <= (a_q[WIDTH-1] == add_b[WIDTH-1]) && (s[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
    end
  end
endmodule

// File: tb/tb_rca64_seq_wrapper.sv
// tb_rca64_seq_wrapper: directed scoreboard bench for rca64_seq_wrapper (define RCA64_OVF_EN to cover out_ovf)
`timescale 1ns/1ps
module tb_rca64_seq_wrapper;
  localparam int SC = 2;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_cin = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [63:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_cout;
  logic [63:0] out_sum;
`ifdef RCA64_OVF_EN
  logic out_ovf;
`endif
  typedef struct packed {logic [63:0] sum; logic cout; logic ovf;} res_t;
  res_t q[$];
  int total = 0, bad = 0;

  rca64_seq_wrapper #(.WIDTH(64), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef RCA64_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [63:0] a, b, input logic c, s);
    res_t r;
    logic [63:0] bb;
    logic [64:0] t;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + 65'(s | c);
    r.sum = t[63:0];
    r.cout = t[64];
    r.ovf = (a[63] == bb[63]) && (t[63] != a[63]);
    return r;
  endfunction

  // plan expectations carry sum/cout; ovf comes from the model
  task automatic send(input logic [63:0] a, b, input logic c, s, input logic [64:0] exp);
    res_t r;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before_send", 65'(in_ready), 65'(1));
    in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1;
    r = model(a, b, c, s);
    r.cout = exp[64];
    r.sum = exp[63:0];
    q.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 1;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("latency", 65'(n - 1), 65'(SC));
  endtask

  task automatic check_out();
    res_t r;
    if (q.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    r = q.pop_front();
    chk("out_sum", {1'b0, out_sum}, {1'b0, r.sum});
    chk("out_cout", 65'(out_cout), 65'(r.cout));
`ifdef RCA64_OVF_EN
    chk("out_ovf", 65'(out_ovf), 65'(r.ovf));
`endif
  endtask

  task automatic retire();
    chk("in_ready_in_done", 65'(in_ready), 65'(0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_retire", 65'(in_ready), 65'(1));
    chk("out_valid_after_retire", 65'(out_valid), 65'(0));
  endtask

  task automatic op(input logic [63:0] a, b, input logic c, s, input logic [64:0] exp);
    send(a, b, c, s, exp);
    wait_valid();
    check_out();
    retire();
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic rc, rs;
    res_t m;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 65'(in_ready), 65'(1));
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_out_sum", {1'b0, out_sum}, 65'(0));
    chk("rst_out_cout", 65'(out_cout), 65'(0));
    rst = 1'b0;
    op(64'd56, 64'd57, 1'b0, 1'b0, {1'b0, 64'd113});
    op(64'd100000000000000000, 64'd150000000000000000, 1'b0, 1'b0, {1'b0, 64'd250000000000000000});
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 64'd0});
    op(64'd57, 64'd56, 1'b1, 1'b1, {1'b1, 64'd1});
    op(64'd56, 64'd57, 1'b0, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, {1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      rc = 1'($urandom); rs = 1'($urandom);
      m = model(ra, rb, rc, rs);
      op(ra, rb, rc, rs, {m.cout, m.sum});
    end
    // backpressure: new operands offered while the result waits
    send(64'd5, 64'd6, 1'b0, 1'b0, {1'b0, 64'd11});
    wait_valid();
    check_out();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = 64'd1;
      @(negedge clk);
      chk("bp_out_valid", 65'(out_valid), 65'(1));
      chk("bp_in_ready", 65'(in_ready), 65'(0));
      chk("bp_out_sum", {1'b0, out_sum}, 65'(11));
    end
    in_valid = 1'b0;
    retire();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stray_result", 65'(out_valid), 65'(0));
      chk("sum_held", {1'b0, out_sum}, 65'(11));
    end
    // reset in the middle of SETTLE discards the operation
    send(64'd3, 64'd4, 1'b0, 1'b0, {1'b0, 64'd7});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("midrst_out_valid", 65'(out_valid), 65'(0));
    chk("midrst_in_ready", 65'(in_ready), 65'(1));
    chk("midrst_out_sum", {1'b0, out_sum}, 65'(0));
    chk("midrst_out_cout", 65'(out_cout), 65'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 65'(out_valid), 65'(0));
    end
    // reset and in_valid together: nothing latched
    rst = 1'b1; in_valid = 1'b1; in_a = 64'd9; in_b = 64'd9;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstvalid_in_ready", 65'(in_ready), 65'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstvalid_no_result", 65'(out_valid), 65'(0));
    end
    op(64'd10, 64'd20, 1'b0, 1'b0, {1'b0, 64'd30});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
